// File: rtl/dmem_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_map_pkg
// Description : Memory-map constants shared by the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_map_pkg;

    localparam logic [31:0] OFF_CYCLE = 32'd0;
    localparam logic [31:0] OFF_MBOX  = 32'd1;
    localparam logic [31:0] OFF_DROPS = 32'd2;

    localparam int STAT_FULL  = 31;
    localparam int STAT_EMPTY = 30;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h0000_FFF0;

endpackage
`default_nettype wire

// File: rtl/mbox_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mbox_fifo
// Description : Outbound mailbox FIFO with separate count register, no fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
module mbox_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL_CNT);
    assign o_count   = r_count;
    // A pop in the same edge frees the slot, so a full FIFO still accepts.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data RAM plus CYCLE / MBOX / DROPS memory-mapped registers.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int          RAM_DEPTH  = 4096,
    parameter int          MBOX_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = dmem_map_pkg::DEFAULT_MMIO_BASE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        mbox_valid,
    output logic [31:0] mbox_data,
    input  logic        mbox_ready
);
    import dmem_map_pkg::*;

    localparam int c_RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int c_CW     = $clog2(MBOX_DEPTH) + 1;

    logic [31:0]         r_ram [RAM_DEPTH];
    logic [31:0]         r_cycle;
    logic [31:0]         r_drops;

    logic                w_sel_ram;
    logic                w_sel_cycle;
    logic                w_sel_mbox;
    logic                w_sel_drops;
    logic [c_RAM_AW-1:0] w_ram_idx;
    logic                w_push_req;
    logic                w_pop_req;
    logic                w_drop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_CW-1:0]     w_count;
    logic [31:0]         w_status;

    assign w_sel_ram   = (address_dmem < 32'(RAM_DEPTH));
    assign w_sel_cycle = (address_dmem == MMIO_BASE + OFF_CYCLE);
    assign w_sel_mbox  = (address_dmem == MMIO_BASE + OFF_MBOX);
    assign w_sel_drops = (address_dmem == MMIO_BASE + OFF_DROPS);
    assign w_ram_idx   = address_dmem[c_RAM_AW-1:0];

    assign w_push_req  = wren && w_sel_mbox;
    assign w_pop_req   = mbox_valid && mbox_ready;
    assign w_drop      = w_push_req && w_fifo_full && !w_pop_req;
    assign mbox_valid  = !w_fifo_empty;

    mbox_fifo #(
        .DEPTH (MBOX_DEPTH),
        .WIDTH (32)
    ) u_mbox_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .i_push  (w_push_req),
        .i_pop   (mbox_ready),
        .i_data  (data),
        .o_head  (mbox_data),
        .o_count (w_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (wren && w_sel_ram) begin
            r_ram[w_ram_idx] <= data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle <= '0;
        end else if (wren && w_sel_cycle) begin
            r_cycle <= data;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_drops <= '0;
        end else if (wren && w_sel_drops) begin
            r_drops <= '0;
        end else if (w_drop && (r_drops != '1)) begin
            r_drops <= r_drops + 32'd1;
        end
    end

    always_comb begin
        w_status             = '0;
        w_status[15:0]       = 16'(w_count);
        w_status[STAT_FULL]  = w_fifo_full;
        w_status[STAT_EMPTY] = w_fifo_empty;
    end

    always_comb begin
        q_dmem = '0;
        if (w_sel_ram) begin
            q_dmem = r_ram[w_ram_idx];
        end else if (w_sel_cycle) begin
            q_dmem = r_cycle;
        end else if (w_sel_mbox) begin
            q_dmem = w_status;
        end else if (w_sel_drops) begin
            q_dmem = r_drops;
        end
    end

endmodule
`default_nettype wire
